id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS pipeline; sits directly downstream of the ID-stage sign extender, register file and decoder.
- Captures the 32-bit extended immediate, both register operands, register addresses, PC+4 and decoded control bits, and presents them to the EX stage.
- Contains the load-use hazard detector; on a hazard it inserts a bubble and requests an upstream stall.
- Honours the branch flush from later stages.

---
 rtl/id_ex_pipe_reg.sv | 174 +++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register of the 5-stage MIPS pipeline.
//
// Captures the ID-stage operands, immediate, register addresses, PC+4 and
// decoded control, and presents them to EX one cycle later. Contains the
// load-use hazard detector. On a hazard it loads a bubble and requests an
// upstream hold. A taken-branch flush also loads a bubble and has priority
// over the hazard.
//
// Optional feature: define ID_EX_PERF_CNT_EN to build the stall and flush
// performance counters. Without it, stall_cnt_o and flush_cnt_o are tied to 0.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   valid_i / valid_o       ID / EX holds a real instruction
//   flush_i                 kill the instruction entering EX
//   rs/rt/rd_i|_o           register addresses
//   rs/rt_data_i|_o         register file read data
//   imm_ext_i|_o            sign-extended immediate
//   pc_plus4_i|_o           PC+4
//   reg_write..branch_i|_o  decoded control bits
//   alu_op_i|_o             ALU op code
//   hazard_stall_o          combinational load-use hold request
//   stall_cnt_o/flush_cnt_o performance counters
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic               flush_i,
    input  logic [REG_AW-1:0]  rs_i,
    input  logic [REG_AW-1:0]  rt_i,
    input  logic [REG_AW-1:0]  rd_i,
    input  logic [DATA_W-1:0]  rs_data_i,
    input  logic [DATA_W-1:0]  rt_data_i,
    input  logic [DATA_W-1:0]  imm_ext_i,
    input  logic [DATA_W-1:0]  pc_plus4_i,
    input  logic               reg_write_i,
    input  logic               mem_to_reg_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    input  logic               alu_src_i,
    input  logic               reg_dst_i,
    input  logic               branch_i,
    input  logic [ALUOP_W-1:0] alu_op_i,
    output logic               valid_o,
    output logic [REG_AW-1:0]  rs_o,
    output logic [REG_AW-1:0]  rt_o,
    output logic [REG_AW-1:0]  rd_o,
    output logic [DATA_W-1:0]  rs_data_o,
    output logic [DATA_W-1:0]  rt_data_o,
    output logic [DATA_W-1:0]  imm_ext_o,
    output logic [DATA_W-1:0]  pc_plus4_o,
    output logic               reg_write_o,
    output logic               mem_to_reg_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               alu_src_o,
    output logic               reg_dst_o,
    output logic               branch_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               hazard_stall_o,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        flush_cnt_o
);

    logic               r_valid;
    logic [REG_AW-1:0]  r_rs, r_rt, r_rd;
    logic [DATA_W-1:0]  r_rs_data, r_rt_data, r_imm_ext, r_pc_plus4;
    logic               r_reg_write, r_mem_to_reg, r_mem_read, r_mem_write;
    logic               r_alu_src, r_reg_dst, r_branch;
    logic [ALUOP_W-1:0] r_alu_op;

    logic w_rt_is_src;
    logic w_rt_match;
    logic w_hazard;
    logic w_load;
    logic w_ctrl_en;

    // Only an immediate-form ALU op leaves rt as a pure destination;
    // stores and branches still read it.
    assign w_rt_is_src = !(alu_src_i && !mem_write_i && !branch_i);
    assign w_rt_match  = (r_rt == rs_i) || ((r_rt == rt_i) && w_rt_is_src);

    // Built from flop outputs, so an async reset drops it immediately.
    assign w_hazard = r_valid && r_mem_read && (r_rt != '0) && valid_i && !flush_i
                      && w_rt_match;

    // Flush and hazard both load an all-zero bubble.
    assign w_load    = !flush_i && !w_hazard;
    assign w_ctrl_en = w_load && valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid      <= 1'b0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm_ext    <= '0;
            r_pc_plus4   <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_branch     <= 1'b0;
            r_alu_op     <= '0;
        end else begin
            r_valid      <= w_ctrl_en;
            r_rs         <= w_load ? rs_i       : '0;
            r_rt         <= w_load ? rt_i       : '0;
            r_rd         <= w_load ? rd_i       : '0;
            r_rs_data    <= w_load ? rs_data_i  : '0;
            r_rt_data    <= w_load ? rt_data_i  : '0;
            r_imm_ext    <= w_load ? imm_ext_i  : '0;
            r_pc_plus4   <= w_load ? pc_plus4_i : '0;
            // Control is gated by valid_i so an empty slot can never write state.
            r_reg_write  <= w_ctrl_en & reg_write_i;
            r_mem_to_reg <= w_ctrl_en & mem_to_reg_i;
            r_mem_read   <= w_ctrl_en & mem_read_i;
            r_mem_write  <= w_ctrl_en & mem_write_i;
            r_alu_src    <= w_ctrl_en & alu_src_i;
            r_reg_dst    <= w_ctrl_en & reg_dst_i;
            r_branch     <= w_ctrl_en & branch_i;
            r_alu_op     <= w_ctrl_en ? alu_op_i : '0;
        end
    end

    assign valid_o        = r_valid;
    assign rs_o           = r_rs;
    assign rt_o           = r_rt;
    assign rd_o           = r_rd;
    assign rs_data_o      = r_rs_data;
    assign rt_data_o      = r_rt_data;
    assign imm_ext_o      = r_imm_ext;
    assign pc_plus4_o     = r_pc_plus4;
    assign reg_write_o    = r_reg_write;
    assign mem_to_reg_o   = r_mem_to_reg;
    assign mem_read_o     = r_mem_read;
    assign mem_write_o    = r_mem_write;
    assign alu_src_o      = r_alu_src;
    assign reg_dst_o      = r_reg_dst;
    assign branch_o       = r_branch;
    assign alu_op_o       = r_alu_op;
    assign hazard_stall_o = w_hazard;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Free-running counters; wrap naturally at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hazard) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush_i)  r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Testbench for id_ex_pipe_reg: table-driven vectors with a scoreboard queue
// of expected EX-stage outputs, plus hand-written reset sequences.
module tb_id_ex_pipe_reg;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, flush_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic [31:0] rs_data_i, rt_data_i, imm_ext_i, pc_plus4_i;
    logic        reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i;
    logic        alu_src_i, reg_dst_i, branch_i;
    logic [2:0]  alu_op_i;
    logic        valid_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic [31:0] rs_data_o, rt_data_o, imm_ext_o, pc_plus4_o;
    logic        reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o;
    logic        alu_src_o, reg_dst_o, branch_o;
    logic [2:0]  alu_op_o;
    logic        hazard_stall_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    always #5 clk_i = ~clk_i;

    id_ex_pipe_reg dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .flush_i        (flush_i),
        .rs_i           (rs_i),
        .rt_i           (rt_i),
        .rd_i           (rd_i),
        .rs_data_i      (rs_data_i),
        .rt_data_i      (rt_data_i),
        .imm_ext_i      (imm_ext_i),
        .pc_plus4_i     (pc_plus4_i),
        .reg_write_i    (reg_write_i),
        .mem_to_reg_i   (mem_to_reg_i),
        .mem_read_i     (mem_read_i),
        .mem_write_i    (mem_write_i),
        .alu_src_i      (alu_src_i),
        .reg_dst_i      (reg_dst_i),
        .branch_i       (branch_i),
        .alu_op_i       (alu_op_i),
        .valid_o        (valid_o),
        .rs_o           (rs_o),
        .rt_o           (rt_o),
        .rd_o           (rd_o),
        .rs_data_o      (rs_data_o),
        .rt_data_o      (rt_data_o),
        .imm_ext_o      (imm_ext_o),
        .pc_plus4_o     (pc_plus4_o),
        .reg_write_o    (reg_write_o),
        .mem_to_reg_o   (mem_to_reg_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .alu_src_o      (alu_src_o),
        .reg_dst_o      (reg_dst_o),
        .branch_o       (branch_o),
        .alu_op_o       (alu_op_o),
        .hazard_stall_o (hazard_stall_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    // Control bit order: reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, branch.
    localparam logic [6:0] C_R    = 7'b1000010;
    localparam logic [6:0] C_LW   = 7'b1110100;
    localparam logic [6:0] C_SW   = 7'b0001100;
    localparam logic [6:0] C_ADDI = 7'b1000100;
    localparam logic [6:0] C_BEQ  = 7'b0000101;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm, pc;
        logic [6:0]  ctrl;
        logic [2:0]  alu;
    } out_t;

    typedef struct {
        logic        valid, flush;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm, pc;
        logic [6:0]  ctrl;
        logic [2:0]  alu;
        logic        exp_stall, exp_bubble;
    } vec_t;

    out_t act;
    assign act = {valid_o, rs_o, rt_o, rd_o, rs_data_o, rt_data_o, imm_ext_o, pc_plus4_o,
                  reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o, reg_dst_o,
                  branch_o, alu_op_o};

    int   checks = 0;
    int   errors = 0;
    out_t sb_q[$];
    vec_t vecs[19];

    function automatic vec_t mk(logic v, logic f, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, logic [6:0] c, logic [2:0] a,
                                logic st, logic bub, int seed);
        vec_t r;
        r.valid = v;  r.flush = f;  r.rs = rs;  r.rt = rt;  r.rd = rd;
        r.rs_data = 32'h1000_0000 + 32'(seed);
        r.rt_data = 32'h2000_0000 + 32'(seed);
        r.imm     = 32'h0000_0100 + 32'(seed);
        r.pc      = 32'h0040_0000 + 32'(seed * 4);
        r.ctrl = c;  r.alu = a;  r.exp_stall = st;  r.exp_bubble = bub;
        return r;
    endfunction

    // Expected EX contents after the edge, built from the table's own flags.
    function automatic out_t expect_out(vec_t v);
        out_t e = '0;
        if (!v.exp_bubble) begin
            e.valid = v.valid;
            e.rs = v.rs;  e.rt = v.rt;  e.rd = v.rd;
            e.rs_data = v.rs_data;  e.rt_data = v.rt_data;
            e.imm = v.imm;  e.pc = v.pc;
            e.ctrl = v.valid ? v.ctrl : 7'b0;
            e.alu  = v.valid ? v.alu  : 3'b0;
        end
        return e;
    endfunction

    task automatic drive(vec_t v);
        valid_i = v.valid;  flush_i = v.flush;
        rs_i = v.rs;  rt_i = v.rt;  rd_i = v.rd;
        rs_data_i = v.rs_data;  rt_data_i = v.rt_data;
        imm_ext_i = v.imm;  pc_plus4_i = v.pc;
        {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i, reg_dst_i,
         branch_i} = v.ctrl;
        alu_op_i = v.alu;
    endtask

    task automatic chk32(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_out(string name, out_t got, out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        out_t e;
        vec_t v;

        vecs[0]  = mk(1, 0, 1, 2, 3, C_R,        3'b010, 0, 0, 0);
        vecs[0].imm = 32'hFFFF_8000;  vecs[0].rs_data = 32'h1234_5678;
        vecs[0].ctrl = 7'b1000000;                                   // pass-through
        vecs[1]  = mk(1, 0, 1, 5, 0, C_LW,       3'b000, 0, 0, 1);  // lw $5
        vecs[2]  = mk(1, 0, 5, 6, 7, C_R,        3'b010, 1, 1, 2);  // add uses $5: stall
        vecs[3]  = mk(1, 0, 5, 6, 7, C_R,        3'b010, 0, 0, 2);  // re-presented
        vecs[4]  = mk(1, 0, 2, 0, 0, C_LW,       3'b000, 0, 0, 4);  // lw $0
        vecs[5]  = mk(1, 0, 0, 9, 8, C_R,        3'b010, 0, 0, 5);  // rs=0: no stall
        vecs[6]  = mk(1, 0, 1, 5, 0, C_LW,       3'b000, 0, 0, 6);  // lw $5
        vecs[7]  = mk(1, 0, 3, 5, 0, C_ADDI,     3'b010, 0, 0, 7);  // addi rt dest only
        vecs[8]  = mk(1, 0, 1, 5, 0, C_LW,       3'b000, 0, 0, 8);  // lw $5
        vecs[9]  = mk(1, 0, 3, 5, 0, C_SW,       3'b000, 1, 1, 9);  // sw reads rt: stall
        vecs[10] = mk(1, 0, 3, 5, 0, C_SW,       3'b000, 0, 0, 9);
        vecs[11] = mk(1, 0, 1, 4, 0, C_LW,       3'b000, 0, 0, 11); // lw $4
        vecs[12] = mk(1, 1, 4, 6, 7, C_R,        3'b010, 0, 1, 12); // hazard + flush
        vecs[13] = mk(0, 0, 1, 2, 3, 7'b1111111, 3'b111, 0, 0, 13); // invalid: ctrl gated
        vecs[14] = mk(1, 0, 0, 8, 0, C_LW,       3'b000, 0, 0, 14); // lw $8
        vecs[15] = mk(1, 0, 1, 8, 0, C_BEQ,      3'b001, 1, 1, 15); // beq reads rt: stall
        vecs[16] = mk(1, 1, 1, 8, 0, C_BEQ,      3'b001, 0, 1, 15); // flush
        vecs[17] = mk(1, 0, 0, 3, 0, C_LW,       3'b000, 0, 0, 17); // lw $3
        vecs[18] = mk(0, 0, 3, 3, 0, C_R,        3'b010, 0, 0, 18); // valid_i=0: no stall

        // Reset
        rst_i = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 7'b0, 3'b0, 0, 0, 0));
        #12;
        chk_out("reset_outputs", act, '0);
        chk32("reset_stall", 32'(hazard_stall_o), 32'd0);
        chk32("reset_stall_cnt", stall_cnt_o, 32'd0);
        chk32("reset_flush_cnt", flush_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk_i);
            v = vecs[i];
            drive(v);
            #1;
            chk32($sformatf("stall_v%0d", i), 32'(hazard_stall_o), 32'(v.exp_stall));
            sb_q.push_back(expect_out(v));
            @(posedge clk_i);
            #1;
            e = sb_q.pop_front();
            chk_out($sformatf("out_v%0d", i), act, e);
        end

`ifdef ID_EX_PERF_CNT_EN
        chk32("stall_cnt", stall_cnt_o, 32'd3);
        chk32("flush_cnt", flush_cnt_o, 32'd2);
`else
        chk32("stall_cnt", stall_cnt_o, 32'd0);
        chk32("flush_cnt", flush_cnt_o, 32'd0);
`endif

        // Reset asserted in the middle of a stall
        @(negedge clk_i);
        drive(mk(1, 0, 0, 31, 0, C_LW, 3'b000, 0, 0, 30));
        @(posedge clk_i);
        #1;
        chk32("lw31_valid", 32'(valid_o), 32'd1);
        @(negedge clk_i);
        drive(mk(1, 0, 31, 31, 31, 7'b1111111, 3'b111, 1, 1, 31));
        #1;
        chk32("pre_reset_stall", 32'(hazard_stall_o), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        chk32("midstall_reset_stall", 32'(hazard_stall_o), 32'd0);
        chk_out("midstall_reset_outputs", act, '0);
        chk32("midstall_reset_stall_cnt", stall_cnt_o, 32'd0);
        chk32("midstall_reset_flush_cnt", flush_cnt_o, 32'd0);

        // All inputs at 1 while reset is held across an edge
        valid_i = 1'b1;  flush_i = 1'b1;
        rs_i = '1;  rt_i = '1;  rd_i = '1;
        rs_data_i = '1;  rt_data_i = '1;  imm_ext_i = '1;  pc_plus4_i = '1;
        {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i, reg_dst_i,
         branch_i} = 7'h7F;
        alu_op_i = '1;
        @(posedge clk_i);
        #1;
        chk_out("held_reset_outputs", act, '0);
        chk32("held_reset_stall", 32'(hazard_stall_o), 32'd0);
        chk32("held_reset_flush_cnt", flush_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
